// File: rtl/exec_divider.sv
// Iterative 32-bit RISC-V divider for the execute stage.
// Restoring radix-2, one quotient bit per cycle, with bypass for corner cases.
package riscv_defines;

  typedef enum logic [2:0] {
    ALUOP_ADD,
    ALUOP_LOGIC,
    ALUOP_SHIFT,
    ALUOP_MUL,
    ALUOP_DIV,
    ALUOP_BRANCH
  } aluop_t;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alucontrol_t;

endpackage

module exec_divider
  import riscv_defines::*;
(
  input  logic        clk,
  input  logic        start,
  input  logic        flush,
  input  logic        ex_fire,
  input  aluop_t      aluop,
  input  alucontrol_t alucontrol,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        div_busy,
  output logic        div_valid,
  output logic [31:0] divresult
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] q_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic [4:0]  cnt_r;
  alucontrol_t op_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        byp_r;

  logic        acc;
  logic        in_sgn;
  logic        in_rem;
  logic        known;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        c_bad;
  logic        c_zero;
  logic        c_ovf;
  logic        bypass;
  logic [31:0] byp_val;
  logic [32:0] r_sh;
  logic [32:0] diff;
  logic        ge;
  logic        op_rem;
  logic [31:0] fin;

  assign div_busy = (state != IDLE);

  // Operand decode and corner-case detection at the accept edge.
  always_comb begin
    acc    = (state == IDLE) && ex_fire
             && (aluop == ALUOP_DIV) && !flush;
    in_sgn = (alucontrol == ALU_DIV)
             || (alucontrol == ALU_REM);
    in_rem = (alucontrol == ALU_REM)
             || (alucontrol == ALU_REMU);
    known  = in_sgn || in_rem
             || (alucontrol == ALU_DIVU);
    a_neg  = in_sgn && in_a[31];
    b_neg  = in_sgn && in_b[31];
    mag_a  = a_neg ? (32'd0 - in_a) : in_a;
    mag_b  = b_neg ? (32'd0 - in_b) : in_b;
    c_bad  = !known;
    c_zero = known && (in_b == 32'd0);
    c_ovf  = known && in_sgn
             && (in_a == 32'h8000_0000)
             && (in_b == 32'hFFFF_FFFF);
    bypass = c_bad || c_zero || c_ovf;
    byp_val = 32'd0;
    unique case (1'b1)
      c_bad:  byp_val = 32'd0;
      c_zero: byp_val = in_rem ? in_a : 32'hFFFF_FFFF;
      c_ovf:  byp_val = in_rem ? 32'd0 : 32'h8000_0000;
      default: byp_val = 32'd0;
    endcase
  end

  // One restoring step plus final sign correction.
  always_comb begin
    r_sh   = {rem_r, q_r[31]};
    diff   = r_sh - {1'b0, dvs_r};
    ge     = r_sh[32] || !diff[32];
    op_rem = (op_r == ALU_REM) || (op_r == ALU_REMU);
    if (byp_r)
      fin = q_r;
    else if (op_rem)
      fin = neg_r_r ? (32'd0 - rem_r) : rem_r;
    else
      fin = neg_q_r ? (32'd0 - q_r) : q_r;
  end

  // State register.
  always_ff @(posedge clk or negedge start) begin
    if (!start)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; flush wins over everything.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = bypass ? DONE : CALC;
      CALC:    if (cnt_r == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  // Datapath: operand latch, iteration, result register.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      q_r       <= '0;
      rem_r     <= '0;
      dvs_r     <= '0;
      cnt_r     <= '0;
      op_r      <= ALU_ADD;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      byp_r     <= 1'b0;
      div_valid <= 1'b0;
      divresult <= '0;
    end else if (flush) begin
      q_r       <= '0;
      rem_r     <= '0;
      dvs_r     <= '0;
      cnt_r     <= '0;
      op_r      <= ALU_ADD;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      byp_r     <= 1'b0;
      div_valid <= 1'b0;
      divresult <= '0;
    end else begin
      div_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            op_r    <= alucontrol;
            rem_r   <= '0;
            cnt_r   <= '0;
            byp_r   <= bypass;
            q_r     <= bypass ? byp_val : mag_a;
            dvs_r   <= bypass ? 32'd0 : mag_b;
            neg_q_r <= !bypass && (a_neg ^ b_neg);
            neg_r_r <= !bypass && a_neg;
          end
        end
        CALC: begin
          q_r   <= {q_r[30:0], ge};
          rem_r <= ge ? diff[31:0] : r_sh[31:0];
          cnt_r <= cnt_r + 5'd1;
        end
        DONE: begin
          divresult <= fin;
          div_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_divider.sv
// Directed bench for exec_divider.
// Checks results, latency, flush and async reset.
module tb_exec_divider;
  import riscv_defines::*;

  logic        clk;
  logic        start;
  logic        flush;
  logic        ex_fire;
  aluop_t      aluop;
  alucontrol_t alucontrol;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        div_busy;
  logic        div_valid;
  logic [31:0] divresult;

  int n_cmp;
  int n_bad;

  exec_divider dut (
    .clk        (clk),
    .start      (start),
    .flush      (flush),
    .ex_fire    (ex_fire),
    .aluop      (aluop),
    .alucontrol (alucontrol),
    .in_a       (in_a),
    .in_b       (in_b),
    .div_busy   (div_busy),
    .div_valid  (div_valid),
    .divresult  (divresult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input string       tag,
    input alucontrol_t ctl,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp,
    input int          lat,
    input bit          noise
  );
    int cyc;
    int bcnt;
    ex_fire    = 1'b1;
    aluop      = ALUOP_DIV;
    alucontrol = ctl;
    in_a       = a;
    in_b       = b;
    @(posedge clk);
    #1;
    ex_fire = 1'b0;
    cyc  = 0;
    bcnt = div_busy ? 1 : 0;
    while (!div_valid && cyc < 60) begin
      if (noise && cyc >= 2 && cyc < 20) begin
        ex_fire    = 1'b1;
        aluop      = ALUOP_DIV;
        alucontrol = ALU_DIVU;
        in_a       = 32'd50;
        in_b       = 32'd5;
      end else begin
        ex_fire = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!div_valid && div_busy) bcnt++;
    end
    ex_fire = 1'b0;
    check({tag, ".lat"}, cyc, lat);
    check({tag, ".busy"}, bcnt, lat);
    check({tag, ".res"}, divresult, exp);
    check({tag, ".vbusy"}, {31'd0, div_busy}, 32'd0);
  endtask

  initial begin
    int vcnt;
    n_cmp      = 0;
    n_bad      = 0;
    start      = 1'b0;
    flush      = 1'b0;
    ex_fire    = 1'b0;
    aluop      = ALUOP_ADD;
    alucontrol = ALU_ADD;
    in_a       = '0;
    in_b       = '0;

    #12;
    check("rst.busy", {31'd0, div_busy}, 32'd0);
    check("rst.valid", {31'd0, div_valid}, 32'd0);
    check("rst.res", divresult, 32'd0);

    @(posedge clk);
    #1;
    start = 1'b1;

    run_op("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    @(posedge clk);
    #1;
    check("hold.valid", {31'd0, div_valid}, 32'd0);
    check("hold.res", divresult, 32'd14);

    run_op("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("div_n7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 33, 0);
    run_op("rem_n7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 33, 0);
    run_op("div_7_n2", ALU_DIV, 32'd7, 32'hFFFF_FFFE,
           32'hFFFF_FFFD, 33, 0);
    run_op("div_z", ALU_DIV, 32'd5, 32'd0,
           32'hFFFF_FFFF, 1, 0);
    run_op("remu_z", ALU_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1, 0);
    run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 1, 0);
    run_op("bad_op", ALU_ADD, 32'd77, 32'd3, 32'd0, 1, 0);
    run_op("rem_n20_6", ALU_REM, 32'hFFFF_FFEC, 32'd6,
           32'hFFFF_FFFE, 33, 0);

    ex_fire    = 1'b1;
    aluop      = ALUOP_DIV;
    alucontrol = ALU_DIVU;
    in_a       = 32'd1000;
    in_b       = 32'd3;
    @(posedge clk);
    #1;
    ex_fire = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush.busy", {31'd0, div_busy}, 32'd0);
    check("flush.valid", {31'd0, div_valid}, 32'd0);
    check("flush.res", divresult, 32'd0);
    run_op("flush_nx", ALU_DIVU, 32'd9, 32'd3, 32'd3, 33, 0);

    run_op("noise", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 1);
    run_op("b2b", ALU_DIVU, 32'd1000, 32'd10, 32'd100, 33, 0);

    ex_fire    = 1'b1;
    aluop      = ALUOP_DIV;
    alucontrol = ALU_DIVU;
    in_a       = 32'd100;
    in_b       = 32'd7;
    @(posedge clk);
    #1;
    ex_fire = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    start = 1'b0;
    #1;
    check("arst.busy", {31'd0, div_busy}, 32'd0);
    check("arst.valid", {31'd0, div_valid}, 32'd0);
    check("arst.res", divresult, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_valid) vcnt++;
    end
    check("arst.nov", vcnt, 0);
    run_op("arst_nx", ALU_DIVU, 32'hFFFF_FFFF, 32'd1,
           32'hFFFF_FFFF, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
